// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared constants for the two-to-one instruction/data memory arbiter:
// message widths and the response-steering tag encoding.
package riscv_mem_arbiter_pkg;

    localparam int unsigned MemReqMsgW  = 67;
    localparam int unsigned MemRespMsgW = 35;

    localparam logic TagImem = 1'b0;
    localparam logic TagDmem = 1'b1;

endpackage

// File: rtl/riscv_mem_arbiter_tagq.sv
// In-order 1-bit tag FIFO recording which requester issued each outstanding
// memory request; its head steers the next returning response.
module riscv_mem_arbiter_tagq #(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  logic tag_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= tag_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin merge of the core's imem and dmem request ports onto one memory
// port; responses are steered back in order using the tag FIFO.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [MemReqMsgW-1:0]  imemreq_msg,
    input  logic                   imemreq_val,
    output logic                   imemreq_rdy,
    output logic [MemRespMsgW-1:0] imemresp_msg,
    output logic                   imemresp_val,

    input  logic [MemReqMsgW-1:0]  dmemreq_msg,
    input  logic                   dmemreq_val,
    output logic                   dmemreq_rdy,
    output logic [MemRespMsgW-1:0] dmemresp_msg,
    output logic                   dmemresp_val,

    output logic [MemReqMsgW-1:0]  memreq_msg,
    output logic                   memreq_val,
    input  logic                   memreq_rdy,
    input  logic [MemRespMsgW-1:0] memresp_msg,
    input  logic                   memresp_val,

    output logic                   err_spurious
);

    logic last_grant_q;
    logic err_spurious_q;
    logic grant;
    logic full, empty, head;
    logic fire, pop;

    // On a tie the requester that did not win the last fire goes next.
    always_comb begin
        grant = TagImem;
        if (imemreq_val && dmemreq_val) begin
            grant = ~last_grant_q;
        end else if (dmemreq_val) begin
            grant = TagDmem;
        end
    end

    assign memreq_val  = reset & (imemreq_val | dmemreq_val) & ~full;
    assign memreq_msg  = (grant == TagDmem) ? dmemreq_msg : imemreq_msg;
    assign imemreq_rdy = reset & memreq_rdy & ~full & (grant == TagImem);
    assign dmemreq_rdy = reset & memreq_rdy & ~full & (grant == TagDmem);

    assign fire = memreq_val & memreq_rdy;
    assign pop  = reset & memresp_val & ~empty;

    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;
    assign imemresp_val = pop & (head == TagImem);
    assign dmemresp_val = pop & (head == TagDmem);

    assign err_spurious = err_spurious_q;

    riscv_mem_arbiter_tagq #(
        .Depth (MAX_OUTSTANDING)
    ) u_tagq (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fire),
        .pop_i   (pop),
        .tag_i   (grant),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q   <= TagImem;
            err_spurious_q <= 1'b0;
        end else begin
            if (fire) begin
                last_grant_q <= grant;
            end
            if (memresp_val && empty) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: single request, round-robin ties,
// backpressure, full FIFO, spurious responses and mid-operation reset.
module tb_riscv_mem_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [66:0]   imemreq_msg, dmemreq_msg, memreq_msg;
    logic          imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
    logic [34:0]   imemresp_msg, dmemresp_msg, memresp_msg;
    logic          imemresp_val, dmemresp_val;
    logic          memreq_val, memreq_rdy, memresp_val;
    logic          err_spurious;

    int errors = 0;
    int checks = 0;

    localparam logic [66:0] IMSG_A = 67'h0_0000_0100_0000_0000;
    localparam logic [66:0] IMSG   = 67'h1_2345_6789_ABCD_EF01;
    localparam logic [66:0] DMSG   = 67'h6_FEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imemreq_msg),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemresp_msg (imemresp_msg),
        .imemresp_val (imemresp_val),
        .dmemreq_msg  (dmemreq_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemresp_msg (dmemresp_msg),
        .dmemresp_val (dmemresp_val),
        .memreq_msg   (memreq_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memresp_msg  (memresp_msg),
        .memresp_val  (memresp_val),
        .err_spurious (err_spurious)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        imemreq_msg = IMSG;
        dmemreq_msg = DMSG;
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = '0;
        #2;
        chk("rst_memreq_val", 67'(memreq_val), 67'd0);
        chk("rst_irdy", 67'(imemreq_rdy), 67'd0);
        chk("rst_drdy", 67'(dmemreq_rdy), 67'd0);
        chk("rst_resp_val", 67'({imemresp_val, dmemresp_val}), 67'd0);
        chk("rst_err", 67'(err_spurious), 67'd0);
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        memresp_val = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Single imem request, answered one cycle later
        imemreq_msg = IMSG_A;
        imemreq_val = 1'b1;
        #1;
        chk("t1_memreq_val", 67'(memreq_val), 67'd1);
        chk("t1_memreq_msg", memreq_msg, IMSG_A);
        chk("t1_irdy", 67'(imemreq_rdy), 67'd1);
        chk("t1_drdy", 67'(dmemreq_rdy), 67'd0);
        tick();
        imemreq_val = 1'b0;
        imemreq_msg = IMSG;
        memresp_val = 1'b1;
        memresp_msg = 35'h0_DEAD_BEEF;
        #1;
        chk("t1_iresp_val", 67'(imemresp_val), 67'd1);
        chk("t1_dresp_val", 67'(dmemresp_val), 67'd0);
        chk("t1_iresp_msg", 67'(imemresp_msg), 67'h0_DEAD_BEEF);
        tick();
        memresp_val = 1'b0;

        // Simultaneous requests: grants D, I, D, I
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_grant_msg", memreq_msg, (i % 2 == 0) ? DMSG : IMSG);
            chk("t2_drdy", 67'(dmemreq_rdy), (i % 2 == 0) ? 67'd1 : 67'd0);
            tick();
        end
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        memresp_val = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            memresp_msg = 35'(i);
            #1;
            chk("t2_dresp_val", 67'(dmemresp_val), (i % 2 == 1) ? 67'd1 : 67'd0);
            chk("t2_iresp_val", 67'(imemresp_val), (i % 2 == 0) ? 67'd1 : 67'd0);
            chk("t2_resp_msg", 67'(dmemresp_msg), 67'(i));
            tick();
        end
        memresp_val = 1'b0;

        // Backpressure: dmem keeps priority while stalled
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        memreq_rdy  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_val", 67'(memreq_val), 67'd1);
            chk("t3_stall_rdy", 67'({imemreq_rdy, dmemreq_rdy}), 67'd0);
            chk("t3_stall_msg", memreq_msg, DMSG);
            tick();
        end
        memreq_rdy = 1'b1;
        #1;
        chk("t3_dfire", 67'(dmemreq_rdy), 67'd1);
        tick();
        chk("t3_ifire", 67'(imemreq_rdy), 67'd1);
        tick();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        memresp_val = 1'b1;
        #1;
        chk("t3_resp0_d", 67'(dmemresp_val), 67'd1);
        tick();
        chk("t3_resp1_i", 67'(imemresp_val), 67'd1);
        tick();
        memresp_val = 1'b0;

        // Full: four imem requests fill the FIFO
        imemreq_val = 1'b1;
        repeat (4) tick();
        memresp_val = 1'b1;
        #1;
        chk("t4_full_val", 67'(memreq_val), 67'd0);
        chk("t4_full_rdy", 67'({imemreq_rdy, dmemreq_rdy}), 67'd0);
        chk("t4_full_pop", 67'(imemresp_val), 67'd1);
        tick();
        memresp_val = 1'b0;
        #1;
        chk("t4_after_pop_val", 67'(memreq_val), 67'd1);
        chk("t4_after_pop_rdy", 67'(imemreq_rdy), 67'd1);
        tick();
        imemreq_val = 1'b0;
        memresp_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_drain", 67'(imemresp_val), 67'd1);
            tick();
        end

        // Spurious response with empty FIFO
        #1;
        chk("t5_spur_resp", 67'({imemresp_val, dmemresp_val}), 67'd0);
        chk("t5_err_before", 67'(err_spurious), 67'd0);
        tick();
        memresp_val = 1'b0;
        chk("t5_err_set", 67'(err_spurious), 67'd1);
        repeat (3) tick();
        chk("t5_err_sticky", 67'(err_spurious), 67'd1);

        // Reset mid-operation: imem then dmem outstanding, last grant = dmem
        imemreq_val = 1'b1;
        tick();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b1;
        tick();
        imemreq_val = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_val", 67'(memreq_val), 67'd0);
        chk("t6_rst_rdy", 67'({imemreq_rdy, dmemreq_rdy}), 67'd0);
        chk("t6_rst_err", 67'(err_spurious), 67'd0);
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        memresp_val = 1'b1;
        #1;
        chk("t6_stale_resp", 67'({imemresp_val, dmemresp_val}), 67'd0);
        tick();
        memresp_val = 1'b0;
        chk("t6_stale_err", 67'(err_spurious), 67'd1);
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        #1;
        chk("t6_tie_d", 67'(dmemreq_rdy), 67'd1);
        chk("t6_tie_msg", memreq_msg, DMSG);
        tick();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        memresp_val = 1'b1;
        #1;
        chk("t6_resp_d", 67'(dmemresp_val), 67'd1);
        tick();
        memresp_val = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
